// File: rtl/spi_arb_pkg.sv
// Shared types and default widths for the SPI command arbiter.
// The id width helper keeps the index at least one bit wide.
package spi_arb_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_MOSI_DW   = 24;
    localparam int DEF_MISO_DW   = 8;
    localparam int DEF_TIMEOUT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BSY,
        WAIT_DONE,
        ACK
    } arb_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first asserted request at or after ptr,
// wrapping from NUM_REQ-1 back to 0.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     id,
    output logic               valid
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [IDW:0]         off_sel;
    logic [IDW:0]         id_sum;

    // Rotate so that bit 0 of req_rot corresponds to requester ptr.
    assign req_dbl = {req, req};
    assign req_rot = NUM_REQ'(req_dbl >> ptr);

    always_comb begin
        off_sel = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off_sel = (IDW + 1)'(i);
            end
        end
        id_sum = {1'b0, ptr} + off_sel;
        if (id_sum >= (IDW + 1)'(NUM_REQ)) begin
            id_sum = id_sum - (IDW + 1)'(NUM_REQ);
        end
        id    = id_sum[IDW-1:0];
        valid = |req;
    end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter sharing one SPI master between several config requesters;
// holds a grant for a whole transaction and returns read data with a per-requester ack.
module spi_cmd_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ         = DEF_NUM_REQ,
    parameter int MOSI_DATA_WIDTH = DEF_MOSI_DW,
    parameter int MISO_DATA_WIDTH = DEF_MISO_DW,
    parameter int TIMEOUT_W       = DEF_TIMEOUT_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 i_req_wr,
    input  logic [NUM_REQ-1:0]                 i_req_rd,
    input  logic [NUM_REQ*MOSI_DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]                 o_ack,
    output logic                               o_err,
    output logic [MISO_DATA_WIDTH-1:0]         o_rd_data,
    output logic [NUM_REQ-1:0]                 o_spi_sel,
    output logic                               o_spi_wr_cmd,
    output logic                               o_spi_rd_cmd,
    output logic [MOSI_DATA_WIDTH-1:0]         o_spi_wr_data,
    input  logic [MISO_DATA_WIDTH-1:0]         i_spi_rd_data,
    input  logic                               i_spi_busy
);

    localparam int IDW = id_width(NUM_REQ);
    localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

    arb_state_t                 state_reg, state_next;
    logic [IDW-1:0]             id_reg, id_next;
    logic [IDW-1:0]             ptr_reg, ptr_next;
    logic [MOSI_DATA_WIDTH-1:0] data_reg, data_next;
    logic                       rd_reg, rd_next;
    logic                       err_reg, err_next;
    logic [TIMEOUT_W-1:0]       wd_reg, wd_next;
    logic [MISO_DATA_WIDTH-1:0] rd_data_reg, rd_data_next;

    logic [MOSI_DATA_WIDTH-1:0] req_words [NUM_REQ];
    logic [NUM_REQ-1:0]         req_any;
    logic [NUM_REQ-1:0]         id_onehot;
    logic [IDW-1:0]             pick_id;
    logic                       pick_valid;
    logic                       wd_expired;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_words[gi] = i_req_data[gi*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH];
            assign req_any[gi]   = i_req_wr[gi] | i_req_rd[gi];
            assign id_onehot[gi] = (id_reg == IDW'(gi));
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .req   (req_any),
        .ptr   (ptr_reg),
        .id    (pick_id),
        .valid (pick_valid)
    );

    assign wd_expired = (wd_reg == WD_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            id_reg      <= '0;
            ptr_reg     <= '0;
            data_reg    <= '0;
            rd_reg      <= 1'b0;
            err_reg     <= 1'b0;
            wd_reg      <= '0;
            rd_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            id_reg      <= id_next;
            ptr_reg     <= ptr_next;
            data_reg    <= data_next;
            rd_reg      <= rd_next;
            err_reg     <= err_next;
            wd_reg      <= wd_next;
            rd_data_reg <= rd_data_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        id_next      = id_reg;
        ptr_next     = ptr_reg;
        data_next    = data_reg;
        rd_next      = rd_reg;
        err_next     = err_reg;
        wd_next      = '0;
        rd_data_next = rd_data_reg;

        case (state_reg)
            IDLE: begin
                if (pick_valid && !i_spi_busy) begin
                    id_next    = pick_id;
                    data_next  = req_words[pick_id];
                    // Write wins when a requester raises both lines.
                    rd_next    = !i_req_wr[pick_id];
                    err_next   = 1'b0;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT_BSY;
            end
            WAIT_BSY: begin
                wd_next = wd_expired ? wd_reg : wd_reg + TIMEOUT_W'(1);
                if (i_spi_busy) begin
                    state_next = WAIT_DONE;
                end else if (wd_expired) begin
                    err_next   = 1'b1;
                    state_next = ACK;
                end
            end
            WAIT_DONE: begin
                wd_next = wd_expired ? wd_reg : wd_reg + TIMEOUT_W'(1);
                if (!i_spi_busy) begin
                    if (rd_reg) begin
                        rd_data_next = i_spi_rd_data;
                    end
                    state_next = ACK;
                end else if (wd_expired) begin
                    err_next   = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                ptr_next   = (id_reg == IDW'(NUM_REQ - 1)) ? '0 : id_reg + IDW'(1);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so an async reset clears them at once.
    assign o_spi_sel     = (state_reg != IDLE) ? id_onehot : '0;
    assign o_spi_wr_cmd  = (state_reg == ISSUE) && !rd_reg;
    assign o_spi_rd_cmd  = (state_reg == ISSUE) && rd_reg;
    assign o_spi_wr_data = ((state_reg == ISSUE) || (state_reg == WAIT_BSY) ||
                            (state_reg == WAIT_DONE)) ? data_reg : '0;
    assign o_ack         = (state_reg == ACK) ? id_onehot : '0;
    assign o_err         = (state_reg == ACK) && err_reg;
    assign o_rd_data     = rd_data_reg;

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Scoreboard bench for spi_cmd_arbiter: expected transactions are queued when
// requests are raised and checked at each command pulse and each ack.
module tb_spi_cmd_arbiter;

    localparam int N  = 4;
    localparam int MW = 24;
    localparam int SW = 8;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_wr = '0;
    logic [N-1:0]  req_rd = '0;
    logic [N*MW-1:0] req_data = '0;
    logic [N-1:0]  ack;
    logic          err;
    logic [SW-1:0] rd_data;
    logic [N-1:0]  spi_sel;
    logic          spi_wr_cmd;
    logic          spi_rd_cmd;
    logic [MW-1:0] spi_wr_data;
    logic [SW-1:0] spi_rd_data = '0;
    logic          busy_m = 1'b0;
    logic          busy_f = 1'b0;
    logic          spi_busy;

    assign spi_busy = busy_m | busy_f;

    always #5 clk = ~clk;

    spi_cmd_arbiter #(
        .NUM_REQ         (N),
        .MOSI_DATA_WIDTH (MW),
        .MISO_DATA_WIDTH (SW),
        .TIMEOUT_W       (TW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req_wr      (req_wr),
        .i_req_rd      (req_rd),
        .i_req_data    (req_data),
        .o_ack         (ack),
        .o_err         (err),
        .o_rd_data     (rd_data),
        .o_spi_sel     (spi_sel),
        .o_spi_wr_cmd  (spi_wr_cmd),
        .o_spi_rd_cmd  (spi_rd_cmd),
        .o_spi_wr_data (spi_wr_data),
        .i_spi_rd_data (spi_rd_data),
        .i_spi_busy    (spi_busy)
    );

    typedef struct {
        logic [N-1:0]  sel;
        bit            rd;
        logic [MW-1:0] data;
        bit            err;
        logic [SW-1:0] rdd;
        int            busy_len;
        bit            no_busy;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    exp_t          mst_e;
    int            rem [N];
    bit            rd_mode [N];
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            cmd_count = 0;
    int            cmd_cyc = 0;
    logic [SW-1:0] last_rd = '0;
    bit            prev_cmd = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_txn(input int k, input bit rd, input logic [MW-1:0] data,
                              input logic [SW-1:0] rdd, input int blen, input bit nob,
                              input bit e_err);
        exp_t e;
        e.sel      = N'(1) << k;
        e.rd       = rd;
        e.data     = data;
        e.err      = e_err;
        e.rdd      = rdd;
        e.busy_len = blen;
        e.no_busy  = nob;
        sb_q.push_back(e);
    endtask

    task automatic start_req(input int k, input bit rd, input logic [MW-1:0] data, input int count);
        req_data[k*MW +: MW] = data;
        rd_mode[k] = rd;
        rem[k] = rem[k] + count;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while (sb_q.size() > 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (sb_q.size() > 0) begin
            check_eq("drain_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Requesters: hold req until ack, drop on the ack cycle, re-raise while work remains.
    initial begin
        for (int k = 0; k < N; k++) begin
            rem[k] = 0;
            rd_mode[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (ack[k]) begin
                    req_wr[k] = 1'b0;
                    req_rd[k] = 1'b0;
                    if (rem[k] > 0) rem[k] = rem[k] - 1;
                end else if (rem[k] > 0 && !req_wr[k] && !req_rd[k]) begin
                    if (rd_mode[k]) req_rd[k] = 1'b1;
                    else            req_wr[k] = 1'b1;
                end
            end
        end
    end

    // SPI master model: busy rises the cycle after a command, falls after busy_len cycles.
    initial begin
        forever begin
            @(negedge clk);
            if ((spi_wr_cmd || spi_rd_cmd) && sb_q.size() > 0 && !sb_q[0].no_busy) begin
                mst_e = sb_q[0];
                @(negedge clk);
                busy_m = 1'b1;
                repeat (mst_e.busy_len) @(negedge clk);
                spi_rd_data = mst_e.rd ? mst_e.rdd : SW'($urandom);
                busy_m = 1'b0;
            end
        end
    end

    // Monitor: command pulses compared against queue head, acks pop the queue.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_cmd) begin
                check_eq("cmd_one_cycle", {30'd0, spi_rd_cmd, spi_wr_cmd}, 32'd0);
            end
            if (spi_wr_cmd || spi_rd_cmd) begin
                cmd_count++;
                cmd_cyc = cyc;
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_cmd", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q[0];
                    $display("cmd  cyc=%0d sel=%b rd=%0b data=%h", cyc, spi_sel, spi_rd_cmd, spi_wr_data);
                    check_eq("cmd_sel", 32'(spi_sel), 32'(mon_e.sel));
                    check_eq("cmd_type", {30'd0, spi_rd_cmd, spi_wr_cmd},
                             mon_e.rd ? 32'd2 : 32'd1);
                    check_eq("cmd_data", 32'(spi_wr_data), 32'(mon_e.data));
                end
            end
            prev_cmd = spi_wr_cmd | spi_rd_cmd;
            if (ack != '0) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    $display("ack  cyc=%0d ack=%b err=%0b rd_data=%h", cyc, ack, err, rd_data);
                    if (mon_e.rd && !mon_e.err) last_rd = mon_e.rdd;
                    check_eq("ack_vec", 32'(ack), 32'(mon_e.sel));
                    check_eq("ack_err", {31'd0, err}, {31'd0, mon_e.err});
                    check_eq("ack_sel", 32'(spi_sel), 32'(mon_e.sel));
                    check_eq("ack_rd_data", 32'(rd_data), 32'(last_rd));
                    if (mon_e.err) begin
                        check_eq("timeout_latency",
                                 {31'd0, (cyc - cmd_cyc >= 15) && (cyc - cmd_cyc <= 18)}, 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

    initial begin
        int c0;
        int w;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_sel", 32'(spi_sel), 32'd0);
        check_eq("rst_cmd", {30'd0, spi_rd_cmd, spi_wr_cmd}, 32'd0);
        check_eq("rst_ack", {27'd0, err, ack}, 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single write from requester 0
        expect_txn(0, 1'b0, 24'h000010, 8'h00, 3, 1'b0, 1'b0);
        start_req(0, 1'b0, 24'h000010, 1);
        wait_drain(200);

        // 2: read from requester 2
        expect_txn(2, 1'b1, 24'h008003, 8'h53, 4, 1'b0, 1'b0);
        start_req(2, 1'b1, 24'h008003, 1);
        wait_drain(200);

        // 6: reset while in WAIT_DONE, then ptr must restart at 0
        expect_txn(2, 1'b1, 24'h00A001, 8'h77, 30, 1'b0, 1'b0);
        c0 = cmd_count;
        start_req(2, 1'b1, 24'h00A001, 1);
        w = 0;
        while (cmd_count == c0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_eq("abort_cmd_seen", 32'(cmd_count - c0), 32'd1);
        repeat (4) @(negedge clk);
        check_eq("pre_rst_sel", 32'(spi_sel), 32'b0100);
        rst = 1'b1;
        #1;
        check_eq("midrst_sel", 32'(spi_sel), 32'd0);
        check_eq("midrst_cmd", {30'd0, spi_rd_cmd, spi_wr_cmd}, 32'd0);
        check_eq("midrst_wr_data", 32'(spi_wr_data), 32'd0);
        check_eq("midrst_ack", {27'd0, err, ack}, 32'd0);
        check_eq("midrst_rd_data", 32'(rd_data), 32'd0);
        sb_q.delete();
        last_rd = '0;
        expect_txn(1, 1'b0, 24'h111111, 8'h00, 2, 1'b0, 1'b0);
        expect_txn(2, 1'b1, 24'h00A001, 8'h3C, 2, 1'b0, 1'b0);
        expect_txn(3, 1'b0, 24'h333333, 8'h00, 2, 1'b0, 1'b0);
        start_req(1, 1'b0, 24'h111111, 1);
        start_req(3, 1'b0, 24'h333333, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_drain(400);

        // 3: fairness, all four requesters for two rounds
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N; k++) begin
                expect_txn(k, k[0], MW'(32'h00C000 + k), SW'(8'h80 + 16 * r + k), 2, 1'b0, 1'b0);
            end
        end
        for (int k = 0; k < N; k++) begin
            start_req(k, k[0], MW'(32'h00C000 + k), 2);
        end
        wait_drain(600);

        // 4: watchdog timeout on requester 0, requester 1 served afterwards
        expect_txn(0, 1'b0, 24'hDEAD00, 8'h00, 0, 1'b1, 1'b1);
        expect_txn(1, 1'b1, 24'h00BEEF, 8'hA5, 3, 1'b0, 1'b0);
        start_req(0, 1'b0, 24'hDEAD00, 1);
        start_req(1, 1'b1, 24'h00BEEF, 1);
        wait_drain(300);

        // 5: master busy while idle holds off the grant; then one requester re-granted twice
        busy_f = 1'b1;
        expect_txn(3, 1'b0, 24'h5A5A5A, 8'h00, 2, 1'b0, 1'b0);
        expect_txn(3, 1'b0, 24'h5A5A5A, 8'h00, 2, 1'b0, 1'b0);
        c0 = cmd_count;
        start_req(3, 1'b0, 24'h5A5A5A, 2);
        repeat (10) @(negedge clk);
        check_eq("busy_hold_cmds", 32'(cmd_count), 32'(c0));
        check_eq("busy_hold_sel", 32'(spi_sel), 32'd0);
        busy_f = 1'b0;
        wait_drain(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
